// File: rtl/decim_frame_buffer.sv
// ---------------------------------------------------------------------------
// decim_frame_buffer
//
// Purpose:
//   Decimates the one-cycle-pulsed output of the FIR low-pass stage (keeps the
//   first of every DECIM pulses), packs the kept samples into FRAME_LEN-sample
//   frames in a two-bank ping-pong buffer and streams completed frames, oldest
//   first, over a valid/ready interface.
//
// Ports:
//   clk_in           system clock
//   rst_in           asynchronous active-low reset
//   audio_in         signed filtered sample, qualified by valid_in
//   valid_in         one-cycle pulse per input sample
//   sample_out       signed decimated sample of the frame being streamed
//   sample_valid_out sample_out is valid
//   sample_ready_in  consumer accepts sample_out this cycle
//   frame_last_out   high with the final sample (index FRAME_LEN-1) of a frame
//   overflow_out     sticky: at least one decimated sample was dropped
//   clear_ovf_in     synchronous clear of overflow_out (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module decim_frame_buffer #(
   parameter int WIDTH     = 16,
   parameter int DECIM     = 4,
   parameter int FRAME_LEN = 64
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic signed [WIDTH-1:0] audio_in,
   input  logic                    valid_in,
   output logic signed [WIDTH-1:0] sample_out,
   output logic                    sample_valid_out,
   input  logic                    sample_ready_in,
   output logic                    frame_last_out,
   output logic                    overflow_out,
   input  logic                    clear_ovf_in
);

   localparam int DC_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int IDX_W  = $clog2(FRAME_LEN);
   localparam int ADDR_W = IDX_W + 1;

   localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DECIM - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;

   // Both banks live in one array; the bank number is the address MSB.
   logic [WIDTH-1:0] bank_mem [0:2*FRAME_LEN-1];

   logic [DC_W-1:0]  decim_cnt_q, decim_cnt_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic             wb_q, wb_d;
   logic [1:0]       full_q, full_d;
   logic             first_q, first_d;   // older of the two banks when both are full
   logic [1:0]       state_q, state_d;
   logic             rb_q, rb_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic [WIDTH-1:0] sample_q, sample_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             ovf_q, ovf_d;

   logic              kept;
   logic              handshake;
   logic [IDX_W-1:0]  rd_idx_inc;
   logic [1:0]        free_vec;
   logic [1:0]        full_free;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [WIDTH-1:0]  mem_wdata;

   always_comb begin
      decim_cnt_d = decim_cnt_q;
      wr_idx_d    = wr_idx_q;
      wb_d        = wb_q;
      full_d      = full_q;
      first_d     = first_q;
      state_d     = state_q;
      rb_d        = rb_q;
      rd_idx_d    = rd_idx_q;
      sample_d    = sample_q;
      valid_d     = valid_q;
      last_d      = last_q;
      ovf_d       = ovf_q;
      free_vec    = 2'b00;
      full_free   = full_q;
      mem_we      = 1'b0;
      mem_waddr   = {wb_q, wr_idx_q};
      mem_wdata   = audio_in;

      kept       = valid_in && (decim_cnt_q == '0);
      handshake  = valid_q && sample_ready_in;
      rd_idx_inc = rd_idx_q + IDX_W'(1);

      // ---------------- decimation counter ----------------
      if (valid_in) begin
         decim_cnt_d = (decim_cnt_q == DC_LAST) ? '0 : decim_cnt_q + DC_W'(1);
      end

      // ---------------- read side ----------------
      case (state_q)
         ST_IDLE: begin
            if (full_q != 2'b00) begin
               // A single full bank is its own index; with both full take the older one.
               rb_d     = (full_q == 2'b11) ? first_q : full_q[1];
               rd_idx_d = '0;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            sample_d = bank_mem[{rb_q, {IDX_W{1'b0}}}];
            valid_d  = 1'b1;
            last_d   = 1'b0;   // frames have at least 4 samples, index 0 is never last
            state_d  = ST_STREAM;
         end
         ST_STREAM: begin
            if (handshake) begin
               if (rd_idx_q != IDX_LAST) begin
                  // Fetch the next sample now so it is presented with no bubble.
                  rd_idx_d = rd_idx_inc;
                  sample_d = bank_mem[{rb_q, rd_idx_inc}];
                  last_d   = (rd_idx_inc == IDX_LAST);
               end else begin
                  free_vec[rb_q] = 1'b1;
                  valid_d        = 1'b0;
                  last_d         = 1'b0;
                  state_d        = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // ---------------- write side ----------------
      // A bank released this cycle is already writable: the free wins.
      full_free = full_q & ~free_vec;
      full_d    = full_free;

      ovf_d = clear_ovf_in ? 1'b0 : ovf_q;

      if (kept) begin
         if (full_free[wb_q]) begin
            // Target bank still holds an unread (or in-flight) frame: drop.
            ovf_d = 1'b1;
         end else begin
            mem_we = 1'b1;
            if (wr_idx_q == IDX_LAST) begin
               full_d[wb_q] = 1'b1;
               first_d      = full_free[~wb_q] ? ~wb_q : wb_q;
               wr_idx_d     = '0;
               wb_d         = ~wb_q;
            end else begin
               wr_idx_d = wr_idx_q + IDX_W'(1);
            end
         end
      end
   end

   // Sample storage: no reset, written only while its bank is not full.
   always_ff @(posedge clk_in) begin
      if (mem_we) begin
         bank_mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         decim_cnt_q <= '0;
         wr_idx_q    <= '0;
         wb_q        <= 1'b0;
         full_q      <= 2'b00;
         first_q     <= 1'b0;
         state_q     <= ST_IDLE;
         rb_q        <= 1'b0;
         rd_idx_q    <= '0;
         sample_q    <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         decim_cnt_q <= decim_cnt_d;
         wr_idx_q    <= wr_idx_d;
         wb_q        <= wb_d;
         full_q      <= full_d;
         first_q     <= first_d;
         state_q     <= state_d;
         rb_q        <= rb_d;
         rd_idx_q    <= rd_idx_d;
         sample_q    <= sample_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         ovf_q       <= ovf_d;
      end
   end

   assign sample_out       = sample_q;
   assign sample_valid_out = valid_q;
   assign frame_last_out   = last_q;
   assign overflow_out     = ovf_q;

endmodule

// File: doc/decim_frame_buffer.md
Name: decim_frame_buffer

Overview:
- Sits directly downstream of the FIR low-pass stage.
- Consumes its one-cycle-pulsed filtered samples and keeps one of every DECIM samples (decimation).
- Packs the kept samples into FRAME_LEN-sample frames in a two-bank ping-pong buffer.
- Streams completed frames to the spectral stage over a valid/ready interface, with a last-sample marker and a sticky overflow flag.

Parameters:
- WIDTH, 16, signed sample width (matches the FIR output).
- DECIM, 4, decimation factor (≥1); keep the 1st of every DECIM input pulses.
- FRAME_LEN, 64, samples per frame (power of two, ≥4).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-low reset.
- audio_in  input  WIDTH  signed filtered sample, qualified by valid_in.
- valid_in  input  1  one-cycle pulse per input sample (the FIR data_ready).
- sample_out  output  WIDTH  signed decimated sample of the current frame.
- sample_valid_out  output  1  sample_out is valid.
- sample_ready_in  input  1  consumer accepts sample_out this cycle.
- frame_last_out  output  1  high with the final (index FRAME_LEN-1) sample of a frame.
- overflow_out  output  1  sticky: at least one decimated sample was dropped.
- clear_ovf_in  input  1  synchronous clear of overflow_out.

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-low on rst_in.
- Reset (rst_in=0, asynchronous):
  - Both banks empty; write bank=0; wr_idx=0; decim_cnt=0; read FSM=IDLE.
  - sample_out=0, sample_valid_out=0, frame_last_out=0, overflow_out=0.
  - Reset mid-frame or mid-stream discards all partial and full frames; no output activity until new input arrives.
- Decimation:
  - decim_cnt increments on each valid_in and wraps DECIM-1→0.
  - The sample is kept only when decim_cnt==0 at the pulse. DECIM=1 keeps every sample.
  - valid_in is ignored while rst_in=0.
- Write side:
  - A kept sample writes bank[wb][wr_idx], then wr_idx++.
  - When wr_idx==FRAME_LEN-1 is written: bank wb is marked full, its frame order is recorded, wr_idx→0, and wb toggles.
  - If the target write bank is full or being read when a kept sample arrives: drop the sample, set overflow_out, leave wr_idx unchanged. Writing resumes at index 0 once that bank is freed.
  - A bank freed and a kept sample arriving in the same cycle: the free wins, the sample is written, no overflow.
- Overflow flag:
  - clear_ovf_in clears overflow_out.
  - A drop in the same cycle as clear_ovf_in sets it (set wins).
- Read FSM:
  - IDLE: if any bank is full, select the oldest full bank, rd_idx=0, go LOAD.
  - LOAD (1 cycle): register bank[rb][0] into sample_out; sample_valid_out=1; frame_last_out=(FRAME_LEN-1==0, i.e. never); go STREAM.
  - STREAM: sample_out, sample_valid_out and frame_last_out hold stable while sample_valid_out && !sample_ready_in. On a handshake:
    - If rd_idx<FRAME_LEN-1: rd_idx++ and present the next sample in the next cycle (no bubble). frame_last_out=1 exactly when the presented index is FRAME_LEN-1.
    - If the handshake is on the last sample: bank rb is marked empty, sample_valid_out=0, frame_last_out=0, go IDLE.
  - Back-to-back frames insert exactly one idle cycle plus the LOAD cycle.
- Latency: the valid_in that completes a frame → sample_valid_out high 3 cycles later (full flag, IDLE→LOAD, LOAD register), provided the reader is idle.
- Arithmetic: no sample arithmetic; samples pass bit-exact; signedness preserved.
- Counter widths: decim_cnt is $clog2(DECIM) wide (min 1); wr_idx and rd_idx are $clog2(FRAME_LEN) wide.
- Storage: plain register arrays or inferred dual-port RAM; the read port must give the LOAD/STREAM timing above.
- Sample_ready_in while sample_valid_out=0 has no effect.

Test Plan:
- Decimation: DECIM=4, FRAME_LEN=8; 32 valid_in pulses carrying 0..31, ready held high → one frame 0,4,8,…,28; frame_last_out only on 28; sample_valid_out rises 3 cycles after pulse 29 (the one carrying 28).
- Backpressure: as above with sample_ready_in toggling 1,0,0,1… → every sample is held stable while stalled; order and values are unchanged; exactly 8 handshakes.
- Ping-pong: DECIM=1, FRAME_LEN=8; 16 consecutive samples (-8..7), ready high → two frames, -8..-1 then 0..7; last marker on -1 and 7; overflow_out=0.
- Overflow and clear: DECIM=1, FRAME_LEN=8; ready low, 24 samples → first 16 are stored, the remaining 8 are dropped, overflow_out=1. Release ready → frames 0..7 then 8..15 are output. Pulse clear_ovf_in → overflow_out=0.
- Simultaneous free/write: with bank 0 streaming and bank 1 full, a kept sample arrives in the same cycle as the last handshake of bank 0 → the sample is written to bank 0 index 0 and overflow_out stays 0.
- Reset mid-stream: assert rst_in=0 asynchronously during STREAM at rd_idx=3 → sample_valid_out, frame_last_out and sample_out go to 0 immediately. After release, 8 new samples (DECIM=1) produce one fresh frame containing only the new data.
